// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and helpers for the BTB write-port scheduler
package btb_pkg;

    // Write-port owner: draining resolves (IDLE) or invalidating every entry (SWEEP).
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Tag covers pc[31:entry_bit+2]; the low two pc bits are always zero.
    function automatic int tag_bits(input int entry_bit);
        return 30 - entry_bit;
    endfunction

    localparam int BTB_ENTRY_BIT = 5;
    localparam int BTB_TAG_BIT   = tag_bits(BTB_ENTRY_BIT);

    // One pending BTB update as seen by the BTB arrays.
    typedef struct packed {
        logic [BTB_ENTRY_BIT-1:0] idx;
        logic [BTB_TAG_BIT-1:0]   tag;
        logic [31:0]              target;
        logic                     is_branch;
    } btb_upd_t;

endpackage

// File: rtl/btb_update_fifo.sv
// rtl/btb_update_fifo.sv - synchronous FIFO holding pending BTB updates
//
// Ports:
//   clk, reset          clock, sync active-high reset (empties the FIFO)
//   push, push_data     write one entry (caller guarantees not full)
//   pop, pop_data       read head entry (pop_data is the head, valid when not empty)
//   clear               drop all entries; a same-cycle push becomes the only entry
//   full, empty, count  occupancy status
module btb_update_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             clear,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= push ? PTR_W'(1) : '0;
            count_q <= push ? CNT_W'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // On clear the surviving push lands in slot 0, where the reset read pointer looks.
    always_ff @(posedge clk) begin
        if (push) mem[clear ? '0 : wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-port scheduler: resolve queue, invalidation sweep, GHR
//
// Ports:
//   clk, reset                       clock, sync active-high reset (starts a full sweep)
//   resolve_valid/ready/pc/target/   EX-stage resolution handshake and payload
//   resolve_is_branch/is_jump/taken
//   inval_req                        fence.i: clear queue and restart the sweep
//   inval_busy, pred_enable          sweep status for fetch
//   btb_wr_en/idx/tag/target/        BTB write port
//   btb_wr_valid/is_branch
//   ghr                              global history, LSB newest
//   queue_count                      pending-update occupancy
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int ENTRY_BIT = 5,
    parameter int HIST_BIT  = 5,
    parameter int QDEPTH    = 4,
    localparam int TAG_BIT  = tag_bits(ENTRY_BIT),
    localparam int CNT_W    = $clog2(QDEPTH) + 1,
    localparam int ENT_W    = ENTRY_BIT + TAG_BIT + 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 resolve_valid,
    output logic                 resolve_ready,
    input  logic [31:0]          resolve_pc,
    input  logic [31:0]          resolve_target,
    input  logic                 resolve_is_branch,
    input  logic                 resolve_is_jump,
    input  logic                 resolve_taken,
    input  logic                 inval_req,
    output logic                 inval_busy,
    output logic                 pred_enable,
    output logic                 btb_wr_en,
    output logic [ENTRY_BIT-1:0] btb_wr_idx,
    output logic [TAG_BIT-1:0]   btb_wr_tag,
    output logic [31:0]          btb_wr_target,
    output logic                 btb_wr_valid,
    output logic                 btb_wr_is_branch,
    output logic [HIST_BIT-1:0]  ghr,
    output logic [CNT_W-1:0]     queue_count
);

    state_t               state;
    logic [ENTRY_BIT-1:0] sweep_idx;
    logic [HIST_BIT-1:0]  ghr_q;

    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             store_branch;
    logic [ENT_W-1:0] push_data;
    logic [ENT_W-1:0] head;

    logic                 head_is_branch;
    logic [31:0]          head_target;
    logic [TAG_BIT-1:0]   head_tag;
    logic [ENTRY_BIT-1:0] head_idx;

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, resolve_pc[1:0]};

    // A jal/jalr that also claims to be a branch is treated purely as a jump.
    assign store_branch  = resolve_is_branch & ~resolve_is_jump;
    assign resolve_ready = ~reset & ~full;
    assign push          = resolve_valid & resolve_ready & (resolve_is_branch | resolve_is_jump);
    assign push_data     = {resolve_pc[ENTRY_BIT+1:2], resolve_pc[31:ENTRY_BIT+2],
                            resolve_target, store_branch};

    // inval_req wins over a pop: the head is being discarded this cycle anyway.
    assign pop = ~reset & (state == IDLE) & ~empty & ~inval_req;

    assign {head_idx, head_tag, head_target, head_is_branch} = head;

    btb_update_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .clear     (inval_req),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Reset lands in SWEEP so the BTB arrays are scrubbed without their own reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            ghr_q     <= '0;
        end else begin
            if (push && store_branch) ghr_q <= {ghr_q[HIST_BIT-2:0], resolve_taken};
            if (inval_req) begin
                state     <= SWEEP;
                sweep_idx <= '0;
            end else if (state == SWEEP) begin
                if (&sweep_idx) state <= IDLE;
                sweep_idx <= sweep_idx + ENTRY_BIT'(1);
            end
        end
    end

    always_comb begin
        btb_wr_en        = 1'b0;
        btb_wr_idx       = '0;
        btb_wr_tag       = '0;
        btb_wr_target    = '0;
        btb_wr_valid     = 1'b0;
        btb_wr_is_branch = 1'b0;
        if (!reset && state == SWEEP) begin
            btb_wr_en  = 1'b1;
            btb_wr_idx = sweep_idx;
        end else if (pop) begin
            btb_wr_en        = 1'b1;
            btb_wr_idx       = head_idx;
            btb_wr_tag       = head_tag;
            btb_wr_target    = head_target;
            btb_wr_valid     = 1'b1;
            btb_wr_is_branch = head_is_branch;
        end
    end

    assign inval_busy  = reset | (state == SWEEP);
    assign pred_enable = ~reset & (state == IDLE);
    assign ghr         = reset ? '0 : ghr_q;
    assign queue_count = reset ? '0 : count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        resolve_valid = 1'b0;
    logic        resolve_ready;
    logic [31:0] resolve_pc = '0;
    logic [31:0] resolve_target = '0;
    logic        resolve_is_branch = 1'b0;
    logic        resolve_is_jump = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        inval_req = 1'b0;
    logic        inval_busy;
    logic        pred_enable;
    logic        btb_wr_en;
    logic [4:0]  btb_wr_idx;
    logic [24:0] btb_wr_tag;
    logic [31:0] btb_wr_target;
    logic        btb_wr_valid;
    logic        btb_wr_is_branch;
    logic [4:0]  ghr;
    logic [2:0]  queue_count;

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk(clk), .reset(reset),
        .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
        .resolve_pc(resolve_pc), .resolve_target(resolve_target),
        .resolve_is_branch(resolve_is_branch), .resolve_is_jump(resolve_is_jump),
        .resolve_taken(resolve_taken), .inval_req(inval_req),
        .inval_busy(inval_busy), .pred_enable(pred_enable),
        .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_tag(btb_wr_tag),
        .btb_wr_target(btb_wr_target), .btb_wr_valid(btb_wr_valid),
        .btb_wr_is_branch(btb_wr_is_branch), .ghr(ghr), .queue_count(queue_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a list of pending updates, a remaining-sweep position and a history value.
    typedef struct {
        logic [4:0]  idx;
        logic [24:0] tag;
        logic [31:0] tgt;
        logic        isb;
    } ent_t;

    ent_t mq[$];
    bit   m_sweep = 1'b1;
    int   m_pos = 0;
    logic [4:0] m_ghr = '0;

    always @(negedge clk) begin
        bit   acc;
        ent_t e;
        if (reset) begin
            chk("rst_wr_en", btb_wr_en, 0);
            chk("rst_ready", resolve_ready, 0);
            chk("rst_busy", inval_busy, 1);
            chk("rst_pred", pred_enable, 0);
            chk("rst_ghr", ghr, 0);
            chk("rst_count", queue_count, 0);
            chk("rst_fields", {btb_wr_idx, btb_wr_tag, btb_wr_target, btb_wr_valid, btb_wr_is_branch}, 0);
            mq.delete();
            m_sweep = 1'b1;
            m_pos = 0;
            m_ghr = '0;
        end else begin
            chk("ready", resolve_ready, mq.size() < QD);
            chk("busy", inval_busy, m_sweep);
            chk("pred", pred_enable, !m_sweep);
            chk("ghr", ghr, m_ghr);
            chk("count", queue_count, mq.size());
            if (m_sweep) begin
                chk("sweep_en", btb_wr_en, 1);
                chk("sweep_idx", btb_wr_idx, m_pos);
                chk("sweep_fields", {btb_wr_tag, btb_wr_target, btb_wr_valid, btb_wr_is_branch}, 0);
            end else if (mq.size() > 0 && !inval_req) begin
                chk("drain_en", btb_wr_en, 1);
                chk("drain_idx", btb_wr_idx, mq[0].idx);
                chk("drain_tag", btb_wr_tag, mq[0].tag);
                chk("drain_target", btb_wr_target, mq[0].tgt);
                chk("drain_valid", btb_wr_valid, 1);
                chk("drain_isb", btb_wr_is_branch, mq[0].isb);
            end else begin
                chk("idle_en", btb_wr_en, 0);
            end
            acc = resolve_valid && (mq.size() < QD) && (resolve_is_branch || resolve_is_jump);
            if (!m_sweep && mq.size() > 0 && !inval_req) void'(mq.pop_front());
            if (inval_req) begin
                mq.delete();
                m_sweep = 1'b1;
                m_pos = 0;
            end else if (m_sweep) begin
                if (m_pos == 31) m_sweep = 1'b0;
                m_pos = (m_pos + 1) % 32;
            end
            if (acc) begin
                e.idx = 5'(resolve_pc >> 2);
                e.tag = 25'(resolve_pc >> 7);
                e.tgt = resolve_target;
                e.isb = resolve_is_branch && !resolve_is_jump;
                mq.push_back(e);
                if (e.isb) m_ghr = {m_ghr[3:0], resolve_taken};
            end
        end
    end

    // Drive inputs for one cycle just after the edge; return at that cycle's negedge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit br, input bit jm, input bit tk, input bit inv, output bit acc);
        @(posedge clk);
        #1;
        resolve_valid = v;
        resolve_pc = pc;
        resolve_target = tgt;
        resolve_is_branch = br;
        resolve_is_jump = jm;
        resolve_taken = tk;
        inval_req = inv;
        @(negedge clk);
        acc = v && resolve_ready && (br || jm);
    endtask

    task automatic idle();
        bit a;
        step(0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        bit a;
        int n;
        int first_idle;
        int k0;
        int kl;
        logic [31:0] got[$];

        // 1: one reset cycle then a full 32-entry sweep
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        first_idle = 0;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) idle();
            if (btb_wr_en) n++;
            if (!inval_busy && first_idle == 0) first_idle = k;
        end
        chk("t1_sweep_writes", n, 32);
        chk("t1_busy_falls", first_idle, 33);
        chk("t1_pred", pred_enable, 1);

        // 2: single taken branch in IDLE
        step(1, 32'h104, 32'h0F0, 1, 0, 1, 0, a);
        idle();
        chk("t2_en", btb_wr_en, 1);
        chk("t2_idx", btb_wr_idx, 5'd1);
        chk("t2_tag", btb_wr_tag, 25'h2);
        chk("t2_target", btb_wr_target, 32'h0F0);
        chk("t2_isb", btb_wr_is_branch, 1);
        chk("t2_valid", btb_wr_valid, 1);
        chk("t2_ghr", ghr, 5'b00001);

        // 3: five jumps while sweeping; only four fit
        step(0, 0, 0, 0, 0, 0, 1, a);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i * 16), 0, 1, 0, 0, a);
            if (a) n++;
        end
        chk("t3_accepts", n, 4);
        idle();
        chk("t3_count", queue_count, 4);
        chk("t3_ready", resolve_ready, 0);
        got.delete();
        k0 = -1;
        kl = -1;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (!inval_busy && btb_wr_en && btb_wr_valid) begin
                got.push_back(btb_wr_target);
                if (k0 < 0) k0 = k;
                kl = k;
            end
        end
        chk("t3_drained", got.size(), 4);
        chk("t3_consecutive", kl - k0, 3);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("t3_order", got[i], 32'h1000 + 32'(i * 16));

        // 4: fence.i at sweep idx 10 with a same-cycle jal
        step(0, 0, 0, 0, 0, 0, 1, a);
        for (int i = 0; i < 10; i++) idle();
        step(1, 32'h300, 32'h400, 0, 1, 0, 1, a);
        chk("t4_idx10", btb_wr_idx, 5'd10);
        idle();
        chk("t4_restart_idx", btb_wr_idx, 5'd0);
        chk("t4_count", queue_count, 1);
        for (int i = 0; i < 31; i++) idle();
        idle();
        chk("t4_jal_en", btb_wr_en & btb_wr_valid, 1);
        chk("t4_jal_target", btb_wr_target, 32'h400);
        chk("t4_jal_isb", btb_wr_is_branch, 0);

        // 5: branch history NT,NT,NT,T,T
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) step(1, 32'h600 + 32'(i * 4), 32'h700 + 32'(i * 4), 1, 0, (i >= 3), 0, a);
            else idle();
            if (btb_wr_en && btb_wr_valid) begin
                n++;
                chk("t5_isb", btb_wr_is_branch, 1);
            end
        end
        chk("t5_writes", n, 5);
        chk("t5_ghr", ghr, 5'b00011);

        // 6: fill during sweep, reset with three entries left in IDLE
        step(0, 0, 0, 0, 0, 0, 1, a);
        step(1, 32'h7F0, 32'h7F4, 0, 0, 0, 0, a);
        step(1, 32'h800, 32'h900, 1, 1, 1, 0, a);
        chk("t6_dropped", queue_count, 0);
        for (int i = 0; i < 3; i++) step(1, 32'hA00 + 32'(i * 4), 32'hB00, 0, 1, 0, 0, a);
        idle();
        chk("t6_count", queue_count, 4);
        chk("t6_ghr_kept", ghr, 5'b00011);
        n = 0;
        for (int k = 0; k < 40 && inval_busy; k++) idle();
        chk("t6_reached_idle", inval_busy, 0);
        chk("t6_jump_wins", {btb_wr_en, btb_wr_valid, btb_wr_is_branch}, 3'b110);
        chk("t6_head_target", btb_wr_target, 32'h900);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_count", queue_count, 0);
        chk("t6_rst_en", btb_wr_en, 0);
        chk("t6_rst_ghr", ghr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_restart", {btb_wr_en, btb_wr_idx}, {1'b1, 5'd0});
        for (int i = 0; i < 31; i++) idle();
        idle();
        chk("t6_empty_after", {inval_busy, btb_wr_en, queue_count}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
